cic_interpolator: RTL and testbench

CIC interpolation filter. Raises the sample rate by RATE using NUM_STAGES comb stages at the input rate and NUM_STAGES integrator stages at the output rate. It is the transmit-side counterpart of the CIC decimator and uses the same streaming handshake on both sides. Output backpressure stalls the whole pipeline; input starvation stalls it without corrupting filter state.

---
 rtl/cic_interpolator.sv | 94 +++++++++
 tb/tb_cic_interpolator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interpolator.sv
// rtl/cic_interpolator.sv - CIC interpolator: N combs at input rate, zero-stuffing, N integrators at output rate.
module cic_interpolator #(
  parameter int NUM_STAGES  = 4,
  parameter int RATE        = 24,
  parameter int RATE_WIDTH  = 5,
  parameter int SCALE_WIDTH = 14,
  parameter int DATA_WIDTH  = 19
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_error,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   out_error
);

  localparam int W = DATA_WIDTH + SCALE_WIDTH;

  logic [RATE_WIDTH-1:0]         phase_q, phase_d;
  logic signed [W-1:0]           cd_q [NUM_STAGES];
  logic signed [W-1:0]           cd_d [NUM_STAGES];
  logic signed [W-1:0]           ig_q [NUM_STAGES];
  logic signed [W-1:0]           ig_d [NUM_STAGES];
  logic signed [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;

  logic signed [W-1:0]           c [NUM_STAGES+1];
  logic signed [W-1:0]           x;
  logic                          slot_free, advance, in_xfer, phase_zero;
  logic                          unused_in_error;

  assign unused_in_error = ^in_error;

  always_comb begin
    phase_zero = (phase_q == '0);
    slot_free  = ~out_valid_q | out_ready;
    in_ready   = reset_n & phase_zero & slot_free;
    advance    = reset_n & slot_free & (~phase_zero | in_valid);
    in_xfer    = in_valid & in_ready;

    c[0] = {{SCALE_WIDTH{in_data[DATA_WIDTH-1]}}, in_data};
    for (int k = 1; k <= NUM_STAGES; k++) begin
      c[k] = c[k-1] - cd_q[k-1];
    end
    x = phase_zero ? c[NUM_STAGES] : '0;

    phase_d     = phase_q;
    out_data_d  = out_data_q;
    out_valid_d = advance | (out_valid_q & ~out_ready);
    for (int k = 0; k < NUM_STAGES; k++) begin
      cd_d[k] = in_xfer ? c[k] : cd_q[k];
      ig_d[k] = ig_q[k];
    end

    if (advance) begin
      // Each integrator adds the previous stage's old value, giving one cycle of pipeline per stage.
      ig_d[0] = ig_q[0] + x;
      for (int k = 1; k < NUM_STAGES; k++) begin
        ig_d[k] = ig_q[k] + ig_q[k-1];
      end
      out_data_d = ig_q[NUM_STAGES-1][SCALE_WIDTH +: DATA_WIDTH];
      phase_d    = (phase_q == RATE_WIDTH'(RATE - 1)) ? '0 : phase_q + RATE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        cd_q[k] <= '0;
        ig_q[k] <= '0;
      end
    end else begin
      phase_q     <= phase_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      for (int k = 0; k < NUM_STAGES; k++) begin
        cd_q[k] <= cd_d[k];
        ig_q[k] <= ig_d[k];
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_error = 2'b00;

endmodule

// File: tb/tb_cic_interpolator.sv
// tb/tb_cic_interpolator.sv - scoreboard bench for cic_interpolator against a per-sample filter model.
module tb_cic_interpolator;

  localparam int N  = 4;
  localparam int R  = 24;
  localparam int SW = 14;
  localparam int DW = 19;
  localparam int W  = DW + SW;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [1:0]           in_error = 2'b11;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [1:0]           out_error;

  cic_interpolator dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_error(in_error),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_error(out_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic signed [DW-1:0] sb [$];
  logic signed [DW-1:0] cap [$];
  logic signed [W-1:0]  m_cd [N];
  logic signed [W-1:0]  m_ig [N];
  logic                 acc;
  logic                 hold_pend = 1'b0;
  logic signed [DW-1:0] hold_val;
  logic signed [DW-1:0] last_out;
  int                   acc_count;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_cd[k] = '0;
      m_ig[k] = '0;
    end
  endtask

  // One accepted input yields exactly R output-rate samples; push all of them.
  task automatic model_accept(input logic signed [DW-1:0] s);
    logic signed [W-1:0] cv, nc, xv;
    cv = W'(s);
    for (int k = 0; k < N; k++) begin
      nc = cv - m_cd[k];
      m_cd[k] = cv;
      cv = nc;
    end
    for (int j = 0; j < R; j++) begin
      xv = (j == 0) ? cv : '0;
      sb.push_back(m_ig[N-1][SW +: DW]);
      for (int k = N - 1; k > 0; k--) m_ig[k] = m_ig[k] + m_ig[k-1];
      m_ig[0] = m_ig[0] + xv;
    end
  endtask

  task automatic cycle();
    logic signed [DW-1:0] exp;
    @(negedge clk);
    if (hold_pend) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hold_val);
    end
    hold_pend = reset_n && out_valid && !out_ready;
    hold_val  = out_data;
    acc = 1'b0;
    if (out_valid && out_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_underflow observed=%0d expected=empty_queue_not_popped", out_data);
      end
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        chk("out_data", out_data, exp);
        last_out = out_data;
        cap.push_back(out_data);
      end
    end
    if (in_valid && in_ready) begin
      acc = 1'b1;
      acc_count++;
      model_accept(in_data);
    end
    if (!reset_n) begin
      sb.delete();
      model_clear();
      hold_pend = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc && n < 3 * R);
    chk({tag, "_accept_timeout"}, acc, 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    model_clear();
    acc_count = 0;

    // Reset state
    reset_n = 1'b0;
    cycle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("out_error", out_error, 0);
    reset_n = 1'b1;

    // Zero stream: first output one cycle after first accept, one accept per R clocks
    in_valid = 1'b1;
    in_data  = '0;
    wait_accept("zero");
    chk("zero_first_valid", out_valid, 1);
    acc_count = 0;
    run(10 * R);
    chk("zero_accept_rate", acc_count, 10);

    // Impulse response from clean state
    do_reset();
    cap.delete();
    in_data = DW'(16384);
    wait_accept("imp");
    in_data = '0;
    run(5 * R);
    begin
      int first_nz;
      first_nz = -1;
      for (int i = 0; i < cap.size(); i++) if (cap[i] != 0 && first_nz < 0) first_nz = i;
      chk("imp_first_nonzero_idx", first_nz, N);
    end

    // Constant 16384 with out_ready high: settles to DC gain, accept duty 1/R
    do_reset();
    in_data = DW'(16384);
    run(8 * R);
    acc_count = 0;
    run(10 * R);
    chk("dc_accept_rate", acc_count, 10);
    chk("dc_settled", last_out, 13824);

    // Same stream under random backpressure
    do_reset();
    for (int i = 0; i < 16 * R; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    out_ready = 1'b1;
    run(2 * R);
    chk("bp_settled", last_out, 13824);

    // Starvation gap then resume
    in_valid = 1'b0;
    run(100);
    chk("starve_out_valid", out_valid, 0);
    chk("starve_in_ready", in_ready, 1);
    chk("starve_sb_empty", sb.size(), 0);
    in_valid = 1'b1;
    run(6 * R);
    chk("resume_settled", last_out, 13824);

    // Reset pulse mid-burst at phase 10
    wait_accept("mid");
    run(9);
    reset_n = 1'b0;
    cycle();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 0);
    reset_n = 1'b1;
    #1;
    chk("midrst_restart_ready", in_ready, 1);
    cap.delete();
    wait_accept("restart");
    run(3 * R);
    chk("restart_first_zero", cap[0], 0);
    chk("restart_len", cap.size(), 3 * R);

    // Drain
    in_valid = 1'b0;
    run(2 * R);
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
